pipeline_hazard_ctrl: RTL and testbench

Sequences the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It produces per-stage stall and flush controls and the EX-stage forwarding selects from the decoded control fields. It also holds the pipeline during a post-reset flush window and across data-cache miss handshakes. A saturating miss-cycle counter is kept for performance monitoring.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller: FSM states,
// forwarding selects and the "no register write" writeback mode.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RSTFLUSH = 2'd0,
    S_IDLE     = 2'd1,
    S_WAIT     = 2'd2,
    S_RESUME   = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] NOREGWRITE = 3'b000;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// EX-operand forwarding select: MEM result wins over WB result, x0 never forwards.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  logic [4:0] rd_m,
  input  logic [2:0] reg_write_m,
  input  logic [4:0] rd_w,
  input  logic [2:0] reg_write_w,
  output logic [1:0] sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = used && (reg_write_m != NOREGWRITE) && (rd_m != 5'd0) && (rd_m == rs);
  assign hit_w = used && (reg_write_w != NOREGWRITE) && (rd_w != 5'd0) && (rd_w == rs);

  always_comb begin
    sel = FWD_RF;
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing and EX forwarding for the 5-stage RV32I pipeline,
// including the post-reset flush window and data-cache miss handshake.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int CNT_W            = 16
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [1:0]       RegReadE,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             MemToRegE,
  input  logic [2:0]       RegWriteM,
  input  logic [2:0]       RegWriteW,
  input  logic             JalD,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             DCacheReq,
  input  logic             DCacheMiss,
  input  logic             DCacheAck,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic [CNT_W-1:0] MissCycles
);

  state_t     state;
  state_t     next_state;
  logic [3:0] flush_cnt;
  logic       miss;
  logic       redirect;
  logic       load_use;

  assign miss     = DCacheReq && DCacheMiss;
  assign redirect = BranchE || JalrE;
  assign load_use = MemToRegE && (RdE != 5'd0) &&
                    ((RegReadD[1] && (Rs1D == RdE)) || (RegReadD[0] && (Rs2D == RdE)));

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) state <= S_RSTFLUSH;
    else         state <= next_state;
  end

  // Flush-window countdown and saturating miss-cycle counter
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      flush_cnt  <= 4'(RST_FLUSH_CYCLES);
      MissCycles <= '0;
    end else begin
      if (state == S_RSTFLUSH) flush_cnt <= flush_cnt - 4'd1;
      if (state == S_WAIT && MissCycles != {CNT_W{1'b1}})
        MissCycles <= MissCycles + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RSTFLUSH: if (flush_cnt <= 4'd1) next_state = S_IDLE;
      S_IDLE:     if (miss)              next_state = S_WAIT;
      S_WAIT:     if (DCacheAck)         next_state = S_RESUME;
      S_RESUME:                          next_state = S_IDLE;
      default:                           next_state = S_RSTFLUSH;
    endcase
  end

  // RESUME replays the missed access, so DCacheMiss is not looked at there
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0; StallW = 1'b0;
    FlushF = 1'b0; FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (state == S_RSTFLUSH) begin
      FlushF = 1'b1; FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
    end else if (state == S_WAIT || (state == S_IDLE && miss)) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (redirect) begin
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    end else if (JalD) begin
      FlushD = 1'b1;
    end
  end

  fwd_select u_fwd1 (
    .rs          (Rs1E),
    .used        (RegReadE[1]),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (Forward1E)
  );

  fwd_select u_fwd2 (
    .rs          (Rs2E),
    .used        (RegReadE[0]),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .sel         (Forward2E)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge
// monitor pops and compares them against the hazard controller outputs.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       RegReadD, RegReadE;
  logic             MemToRegE, JalD, BranchE, JalrE;
  logic [2:0]       RegWriteM, RegWriteW;
  logic             DCacheReq, DCacheMiss, DCacheAck;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       Forward1E, Forward2E;
  logic [CNT_W-1:0] MissCycles;

  pipeline_hazard_ctrl #(.RST_FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RegReadE(RegReadE),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .MemToRegE(MemToRegE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .JalD(JalD), .BranchE(BranchE), .JalrE(JalrE),
    .DCacheReq(DCacheReq), .DCacheMiss(DCacheMiss), .DCacheAck(DCacheAck),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .MissCycles(MissCycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [4:0]       stall;
    logic [4:0]       flush;
    logic [1:0]       f1;
    logic [1:0]       f2;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] HOLD = 5'b11110;  // {F,D,E,M,W} stalls during a miss

  wire [4:0] stall_v = {StallF, StallD, StallE, StallM, StallW};
  wire [4:0] flush_v = {FlushF, FlushD, FlushE, FlushM, FlushW};

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (stall_v === mon_e.stall && flush_v === mon_e.flush && Forward1E === mon_e.f1 &&
          Forward2E === mon_e.f2 && MissCycles === mon_e.mc)
        passes++;
      else
        $display("FAIL %s: got stall=%b flush=%b fwd1=%b fwd2=%b miss=%0d, need stall=%b flush=%b fwd1=%b fwd2=%b miss=%0d",
                 mon_e.name, stall_v, flush_v, Forward1E, Forward2E, MissCycles,
                 mon_e.stall, mon_e.flush, mon_e.f1, mon_e.f2, mon_e.mc);
    end
  end

  task automatic push(input string n, input logic [4:0] s, input logic [4:0] f,
                      input logic [1:0] a, input logic [1:0] b, input logic [CNT_W-1:0] m);
    exp_t e;
    e.name = n; e.stall = s; e.flush = f; e.f1 = a; e.f2 = b; e.mc = m;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; RegReadD = 0; Rs1E = 0; Rs2E = 0; RegReadE = 0;
    RdE = 0; RdM = 0; RdW = 0; MemToRegE = 0; RegWriteM = 0; RegWriteW = 0;
    JalD = 0; BranchE = 0; JalrE = 0; DCacheReq = 0; DCacheMiss = 0; DCacheAck = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    cyc(); push("reset_hold", NONE, ALL, 2'b00, 2'b00, 0);
    cyc(); rst = 0; push("rflush_0", NONE, ALL, 2'b00, 2'b00, 0);
    cyc(); push("rflush_1", NONE, ALL, 2'b00, 2'b00, 0);
    cyc(); push("idle_after_flush", NONE, NONE, 2'b00, 2'b00, 0);

    // Forwarding
    cyc(); RdM = 5; RegWriteM = 3; RdW = 5; RegWriteW = 3; Rs1E = 5; RegReadE = 2'b10;
    push("fwd_mem_pri", NONE, NONE, 2'b10, 2'b00, 0);
    cyc(); RdM = 0; push("fwd_wb_rdm0", NONE, NONE, 2'b01, 2'b00, 0);
    cyc(); RdM = 5; RegWriteM = 0; Rs2E = 5; RegReadE = 2'b11;
    push("fwd_wb_nowrite_m", NONE, NONE, 2'b01, 2'b01, 0);
    cyc(); RegWriteM = 3; RdW = 9; Rs2E = 9;
    push("fwd_mixed", NONE, NONE, 2'b10, 2'b01, 0);
    cyc(); RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    push("fwd_x0", NONE, NONE, 2'b00, 2'b00, 0);

    // Load-use, redirect, JAL
    cyc(); clr(); MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
    push("load_use", 5'b11000, 5'b00100, 2'b00, 2'b00, 0);
    cyc(); RdE = 0; push("load_use_x0", NONE, NONE, 2'b00, 2'b00, 0);
    cyc(); RdE = 7; RegReadD = 2'b10; push("load_use_unused", NONE, NONE, 2'b00, 2'b00, 0);
    cyc(); RegReadD = 2'b01; BranchE = 1;
    push("branch_over_lu", NONE, 5'b01100, 2'b00, 2'b00, 0);
    cyc(); BranchE = 0; JalD = 1;
    push("lu_over_jal", 5'b11000, 5'b00100, 2'b00, 2'b00, 0);
    cyc(); clr(); JalD = 1; push("jal_only", NONE, 5'b01000, 2'b00, 2'b00, 0);
    cyc(); clr(); JalrE = 1; push("jalr_redirect", NONE, 5'b01100, 2'b00, 2'b00, 0);

    // Miss with ack four cycles later
    cyc(); clr(); DCacheReq = 1; DCacheMiss = 1;
    push("miss_cycle", HOLD, 5'b00001, 2'b00, 2'b00, 0);
    cyc(); clr(); BranchE = 1; MemToRegE = 1; RdE = 7; Rs2D = 7; RegReadD = 2'b01;
    push("wait_1_suppress", HOLD, 5'b00001, 2'b00, 2'b00, 0);
    cyc(); clr(); push("wait_2", HOLD, 5'b00001, 2'b00, 2'b00, 1);
    cyc(); push("wait_3", HOLD, 5'b00001, 2'b00, 2'b00, 2);
    cyc(); DCacheAck = 1; push("wait_ack", HOLD, 5'b00001, 2'b00, 2'b00, 3);
    cyc(); clr(); DCacheReq = 1; DCacheMiss = 1;
    push("resume_ignores_miss", NONE, NONE, 2'b00, 2'b00, 4);
    cyc(); clr(); DCacheAck = 1; push("idle_ack_ignored", NONE, NONE, 2'b00, 2'b00, 4);
    cyc(); clr(); push("idle_stays", NONE, NONE, 2'b00, 2'b00, 4);

    // Second miss: saturate the counter, then reset mid-WAIT
    cyc(); DCacheReq = 1; DCacheMiss = 1;
    push("miss2_cycle", HOLD, 5'b00001, 2'b00, 2'b00, 4);
    cyc(); clr(); push("miss2_w1", HOLD, 5'b00001, 2'b00, 2'b00, 4);
    cyc(); push("miss2_w2", HOLD, 5'b00001, 2'b00, 2'b00, 5);
    cyc(); push("miss2_w3", HOLD, 5'b00001, 2'b00, 2'b00, 6);
    cyc(); push("miss2_w4", HOLD, 5'b00001, 2'b00, 2'b00, 7);
    cyc(); push("miss2_saturated", HOLD, 5'b00001, 2'b00, 2'b00, 7);
    cyc(); rst = 1; push("rst_async", NONE, ALL, 2'b00, 2'b00, 0);
    cyc(); rst = 0; push("rflush2_0", NONE, ALL, 2'b00, 2'b00, 0);
    cyc(); push("rflush2_1", NONE, ALL, 2'b00, 2'b00, 0);
    cyc(); push("idle2", NONE, NONE, 2'b00, 2'b00, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d entries left, need 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
